uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART 8N1 receiver: the receive-side counterpart of the team's uart_tx.
//  Oversampling is not used. Each bit is sampled once, at mid-bit, by a BAUD_DIV clock divider.
//  Recovered bytes are presented on a one-entry valid/ready output buffer.
//  Framing and overrun errors are flagged as single-cycle pulses.
//  Sits between the asynchronous rx pin and the byte-level consumer (FIFO/CPU bridge).
// PARAMETERS
//  BAUD_DIV  868  clk cycles per bit (100 MHz / 115200). Legal range is >= 4.
//  HALF_DIV  BAUD_DIV/2 (localparam, integer divide)  cycles from start edge to mid-start sample
// PORTS
//  clk          in   1  100 MHz clock
//  resetn       in   1  asynchronous, active-low reset
//  rx           in   1  serial line, asynchronous to clk, idle high
//  out_data     out  8  received byte, valid while out_valid=1
//  out_valid    out  1  byte available; held until accepted
//  out_ready    in   1  consumer accepts; transfer when out_valid & out_ready
//  frame_err    out  1  1-cycle pulse: stop bit sampled 0
//  overrun_err  out  1  1-cycle pulse: byte completed while buffer full and not drained
//  busy         out  1  1 while state != IDLE
// BEHAVIOUR
//  Reset values: out_data=0, out_valid=0, frame_err=0, overrun_err=0, busy=0.
//  Reset also clears the sync flops to 1, sets state to IDLE, and clears all counters and the shift register.
//  Input path: rx goes through a 2-flop synchronizer (rx_s), plus one delay flop (rx_d) for edge detection.
//  Start detection: fall = rx_d & ~rx_s, evaluated only in IDLE.
//  A line that is held low (break, or after a framing error) is not re-armed until a 1->0 edge occurs.
//  FSM states are IDLE, START, DATA and STOP. div_cnt[31:0] and bit_cnt[2:0] are the counters.
//  Timing is given with cycle 0 = the IDLE cycle that sees fall (2-3 clk after the rx pin falls).
//   IDLE : on fall -> START, div_cnt=0.
//   START: div_cnt increments every cycle. At div_cnt==HALF_DIV-1 (cycle HALF_DIV), rx_s is sampled:
//          0 -> DATA with div_cnt=0, bit_cnt=0; 1 -> glitch, return to IDLE with no flags.
//   DATA : at div_cnt==BAUD_DIV-1, div_cnt is cleared and rx_s is shifted in LSB-first (shift <= {rx_s, shift[7:1]}).
//          bit_cnt then increments. The sample taken with bit_cnt==7 moves the FSM to STOP.
//          Bit i is sampled at cycle HALF_DIV + (i+1)*BAUD_DIV.
//   STOP : at div_cnt==BAUD_DIV-1 (cycle HALF_DIV + 9*BAUD_DIV), rx_s is sampled and the FSM returns to IDLE.
//          1 -> byte complete (buffer update below). 0 -> frame_err=1 next cycle; the byte is discarded.
//  Output buffer (updated in the cycle after the stop sample, i.e. cycle HALF_DIV + 9*BAUD_DIV + 1):
//   - empty, or (out_valid & out_ready) in the completion cycle -> out_data=shift, out_valid=1.
//   - out_valid & ~out_ready -> keep old out_data/out_valid, overrun_err=1 for 1 cycle, new byte dropped.
//   - out_valid clears the cycle after out_valid & out_ready with no concurrent completion.
//  The receiver returns to IDLE in the same cycle as the stop sample.
//  A start edge arriving half a bit after the stop sample is therefore caught, giving back-to-back frames with no gap.
//  frame_err and overrun_err are mutually exclusive per frame and never assert for a glitch-rejected start.
//  Reset mid-frame: everything returns to reset values immediately; any partial byte is lost.
//  Arithmetic: div_cnt is 32-bit unsigned, compared by equality. bit_cnt wraps 7->0 only on the DATA->STOP transition.
// TESTING
//  1. uart_tx drives rx with 0xA5, out_ready=1
//     -> out_valid high for 1 cycle with out_data=0xA5 at tx-start + 2 + HALF_DIV + 9*BAUD_DIV + 1 (+/-1); no errors.
//  2. Back-to-back 0x00, 0xFF, 0x55 with zero idle gap, out_ready=1
//     -> three out_valid pulses carrying 0x00, 0xFF, 0x55, spaced 10*BAUD_DIV apart.
//  3. rx low pulse of 200 cycles (less than HALF_DIV=434)
//     -> busy high for 434 cycles, then IDLE; no out_valid and no errors.
//  4. Frame 0x3C with stop bit forced 0, then a valid 0x81
//     -> frame_err 1-cycle pulse, no out_valid for 0x3C; 0x81 is received normally.
//  5. out_ready=0; send 0x11 then 0x22
//     -> out_data stays 0x11 with out_valid=1, overrun_err pulses once at the end of 0x22.
//     -> After raising out_ready, 0x11 is accepted and out_valid drops.
//  6. resetn asserted during bit 4 of a frame
//     -> all outputs go to reset values immediately; the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: single mid-bit sample per bit from a BAUD_DIV divider,
// one-entry valid/ready output buffer, single-cycle framing/overrun pulses.
module uart_rx #(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rx,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int unsigned HALF_DIV = BAUD_DIV / 2;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state, state_nxt;
   logic        rx_meta, rx_s, rx_d;
   logic        fall;
   logic [31:0] div_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic        half_hit, baud_hit;
   logic        stop_ok, stop_bad;

   // Sync flops reset to the idle-high line level so reset never looks like a start edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign fall     = rx_d & ~rx_s;
   assign half_hit = (div_cnt == 32'(HALF_DIV - 1));
   assign baud_hit = (div_cnt == 32'(BAUD_DIV - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (fall) state_nxt = START;
         START: if (half_hit) state_nxt = rx_s ? IDLE : DATA;
         DATA:  if (baud_hit && bit_cnt == 3'd7) state_nxt = STOP;
         STOP:  if (baud_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      stop_ok  = (state == STOP) && baud_hit && rx_s;
      stop_bad = (state == STOP) && baud_hit && !rx_s;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         case (state)
            IDLE: if (fall) div_cnt <= '0;
            START: begin
               if (half_hit) begin
                  div_cnt <= '0;
                  bit_cnt <= '0;
               end else begin
                  div_cnt <= div_cnt + 32'd1;
               end
            end
            DATA: begin
               if (baud_hit) begin
                  div_cnt <= '0;
                  shift   <= {rx_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end else begin
                  div_cnt <= div_cnt + 32'd1;
               end
            end
            STOP: begin
               if (baud_hit) div_cnt <= '0;
               else          div_cnt <= div_cnt + 32'd1;
            end
            default: div_cnt <= '0;
         endcase
      end
   end

   // A completing byte may refill the buffer in the same cycle the old byte is taken.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_data    <= '0;
         out_valid   <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= stop_bad;
         overrun_err <= 1'b0;
         if (stop_ok) begin
            if (!out_valid || out_ready) begin
               out_data  <= shift;
               out_valid <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
